button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 138 +++++++++++++
 tb/tb_button_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-channel debounce with press/release/long-press strobes.
// Latency: DEBOUNCE_CYCLES+3 edges from raw change to strobe; no backpressure (free-running strobes).
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] hold_pulse,
    output logic             any_press
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, ARMING, PRESSED, DISARMING} state_t;

    logic [N_BTN-1:0] press_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          sync_1, sync_2;
        state_t        state_q, state_d;
        logic [DW-1:0] db_q, db_d;
        logic [HW-1:0] hc_q, hc_d;
        logic          hold_done_q, hold_done_d;
        logic          lvl_q, lvl_d;
        logic          pr_q, pr_d, rl_q, rl_d, hd_q, hd_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_1      <= 1'b0;
                sync_2      <= 1'b0;
                state_q     <= RELEASED;
                db_q        <= '0;
                hc_q        <= '0;
                hold_done_q <= 1'b0;
                lvl_q       <= 1'b0;
                pr_q        <= 1'b0;
                rl_q        <= 1'b0;
                hd_q        <= 1'b0;
            end else begin
                sync_1      <= btn_raw[i];
                sync_2      <= sync_1;
                state_q     <= state_d;
                db_q        <= db_d;
                hc_q        <= hc_d;
                hold_done_q <= hold_done_d;
                lvl_q       <= lvl_d;
                pr_q        <= pr_d;
                rl_q        <= rl_d;
                hd_q        <= hd_d;
            end
        end

        always_comb begin
            state_d     = state_q;
            db_d        = db_q;
            hc_d        = hc_q;
            hold_done_d = hold_done_q;
            lvl_d       = lvl_q;
            pr_d        = 1'b0;
            rl_d        = 1'b0;
            hd_d        = 1'b0;
            case (state_q)
                RELEASED: begin
                    lvl_d = 1'b0;
                    if (sync_2) begin
                        state_d = ARMING;
                        db_d    = '0;
                    end
                end
                ARMING: begin
                    if (!sync_2) begin
                        state_d = RELEASED;
                        db_d    = '0;
                    end else if (db_q == DB_LAST) begin
                        state_d     = PRESSED;
                        lvl_d       = 1'b1;
                        pr_d        = 1'b1;
                        hc_d        = '0;
                        hold_done_d = 1'b0;
                    end else begin
                        db_d = db_q + DW'(1);
                    end
                end
                PRESSED: begin
                    lvl_d = 1'b1;
                    if (!sync_2) begin
                        state_d = DISARMING;
                        db_d    = '0;
                    end else if (!hold_done_q) begin
                        // Count saturates at the terminal value once the strobe fires.
                        if (hc_q == HOLD_LAST) begin
                            hd_d        = 1'b1;
                            hold_done_d = 1'b1;
                        end else begin
                            hc_d = hc_q + HW'(1);
                        end
                    end
                end
                DISARMING: begin
                    if (sync_2) begin
                        state_d = PRESSED;
                    end else if (db_q == DB_LAST) begin
                        state_d     = RELEASED;
                        lvl_d       = 1'b0;
                        rl_d        = 1'b1;
                        hc_d        = '0;
                        hold_done_d = 1'b0;
                    end else begin
                        db_d = db_q + DW'(1);
                    end
                end
                default: state_d = RELEASED;
            endcase
        end

        assign press_nxt[i]     = pr_d;
        assign btn_level[i]     = lvl_q;
        assign press_pulse[i]   = pr_q;
        assign release_pulse[i] = rl_q;
        assign hold_pulse[i]    = hd_q;
    end

    // Registered from next-state strobes so it lines up with press_pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_press <= 1'b0;
        else        any_press <= |press_nxt;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed check of button_conditioner against a run-length reference model.
module tb_button_conditioner;
    localparam int N = 5;
    localparam int D = 4;
    localparam int H = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, press_pulse, release_pulse, hold_pulse;
    logic         any_press;

    always #5 clk = ~clk;

    button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .hold_pulse(hold_pulse), .any_press(any_press)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: two-sample input delay, then a run of D+1 samples disagreeing
    // with the accepted level flips it; hold fires on the H-th steady pressed sample.
    logic         m_s1 [N];
    logic         m_s2 [N];
    logic         m_lvl [N];
    logic         m_hdone [N];
    int           m_run [N];
    int           m_hcnt [N];
    logic [N-1:0] e_lvl, e_pr, e_rl, e_hd;
    logic         e_any;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_hdone[c] = 0;
            m_run[c] = 0; m_hcnt[c] = 0;
        end
        e_lvl = '0; e_pr = '0; e_rl = '0; e_hd = '0; e_any = 1'b0;
    endtask

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            logic s;
            s = m_s2[c];
            e_pr[c] = 0; e_rl[c] = 0; e_hd[c] = 0;
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D + 1) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                    m_hcnt[c] = 0;
                    m_hdone[c] = 0;
                    if (s) e_pr[c] = 1; else e_rl[c] = 1;
                end
            end else begin
                if (m_lvl[c] && m_run[c] == 0 && !m_hdone[c]) begin
                    m_hcnt[c]++;
                    if (m_hcnt[c] == H) begin
                        e_hd[c] = 1;
                        m_hdone[c] = 1;
                    end
                end
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_raw[c];
            e_lvl[c] = m_lvl[c];
        end
        e_any = |e_pr;
    endtask

    task automatic check_outputs();
        chk("btn_level", btn_level, e_lvl);
        chk("press_pulse", press_pulse, e_pr);
        chk("release_pulse", release_pulse, e_rl);
        chk("hold_pulse", hold_pulse, e_hd);
        chk("any_press", any_press, e_any);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_level", btn_level, '0);
        chk("rst_pulses", press_pulse | release_pulse | hold_pulse, '0);
        chk("rst_any", any_press, 1'b0);
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    // Ticks until the selected strobe appears on channel ch; returns ticks taken (first edge = 1).
    task automatic wait_strobe(input int ch, input int kind, input int max, output int n);
        logic hit;
        n = 0;
        hit = 0;
        while (!hit && n < max) begin
            tick();
            n++;
            case (kind)
                0: hit = press_pulse[ch];
                1: hit = release_pulse[ch];
                default: hit = hold_pulse[ch];
            endcase
        end
    endtask

    int n;
    int any_cnt;
    int seg_left [N];

    initial begin
        model_reset();
        #2;
        do_reset(3);

        // Channel 0: press lands D+3 edges after the raw edge, level stays high.
        btn_raw[0] = 1'b1;
        wait_strobe(0, 0, 50, n);
        chk("press_latency", n, D + 3);
        chk("any_with_press", any_press, 1'b1);
        tick();
        chk("level0_held", btn_level[0], 1'b1);
        chk("other_levels", btn_level[N-1:1], '0);

        // Channel 1: 3-cycle glitch is rejected.
        btn_raw[1] = 1'b1;
        repeat (3) tick();
        btn_raw[1] = 1'b0;
        repeat (12) tick();
        chk("glitch_level1", btn_level[1], 1'b0);

        // Channel 2: hold strobe H cycles after press, once only; release after D+3.
        btn_raw[2] = 1'b1;
        wait_strobe(2, 0, 50, n);
        chk("press2_latency", n, D + 3);
        wait_strobe(2, 2, 100, n);
        chk("hold_after_press", n, H);
        wait_strobe(2, 2, 30, n);
        chk("no_second_hold", n, 30);
        btn_raw[2] = 1'b0;
        wait_strobe(2, 1, 50, n);
        chk("release_latency", n, D + 3);

        // Channel 3: short low bounce while pressed is absorbed.
        btn_raw[3] = 1'b1;
        repeat (10) tick();
        btn_raw[3] = 1'b0;
        repeat (2) tick();
        btn_raw[3] = 1'b1;
        repeat (15) tick();
        chk("bounce_level3", btn_level[3], 1'b1);

        // Channel 4: reset mid-press discards the press, then re-press after normal latency.
        btn_raw[4] = 1'b1;
        repeat (10) tick();
        chk("pressed4", btn_level[4], 1'b1);
        do_reset(2);
        wait_strobe(4, 0, 50, n);
        chk("press4_after_rst", n, D + 3);

        // Channels 0 and 1 pressed on the same edge: one any_press cycle.
        btn_raw = '0;
        repeat (15) tick();
        btn_raw[1:0] = 2'b11;
        any_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (any_press) begin
                any_cnt++;
                chk("dual_press", press_pulse[1:0], 2'b11);
            end
        end
        chk("any_press_once", any_cnt, 1);

        // Random bouncing on all channels, mixing short glitches and long holds.
        for (int c = 0; c < N; c++) seg_left[c] = 1;
        for (int it = 0; it < 2500; it++) begin
            for (int c = 0; c < N; c++) begin
                seg_left[c]--;
                if (seg_left[c] <= 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    seg_left[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4)
                                                             : $urandom_range(5, 40);
                end
            end
            if (it == 1200) do_reset($urandom_range(1, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
